// File: rtl/cpu_controller.sv
// cpu_controller: fetch/decode/sequence FSM for the simpleRISC datapath.
// Ports: clk, reset_n, memory port (mem_cmd/mem_addr/read_data/write_data/mem_ready),
//        datapath controls (vsel, reg nums, enables, asel/bsel, shift, ALUop),
//        immediates (sximm5/sximm8), PC and halted status.
module cpu_controller (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] read_data,
    input  logic        mem_ready,
    input  logic [15:0] datapath_out,
    input  logic [2:0]  Z_out,
    output logic [1:0]  mem_cmd,
    output logic [8:0]  mem_addr,
    output logic [15:0] write_data,
    output logic [3:0]  vsel,
    output logic [2:0]  writenum,
    output logic [2:0]  readnum,
    output logic        write,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        asel,
    output logic        bsel,
    output logic [1:0]  shift,
    output logic [1:0]  ALUop,
    output logic [15:0] sximm5,
    output logic [15:0] sximm8,
    output logic [8:0]  PC,
    output logic        halted
);

    typedef enum logic [3:0] {
        S_IF, S_DEC, S_WRI, S_GETA, S_GETB, S_EXEC, S_WBR,
        S_ADDR, S_LDA, S_MEMRD, S_GETD, S_STOUT, S_MEMWR, S_HALT
    } state_t;

    localparam logic [1:0] CMD_NONE  = 2'b00;
    localparam logic [1:0] CMD_READ  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;

    state_t      state, state_n;
    logic [8:0]  pc, pc_n;
    logic [8:0]  dar, dar_n;
    logic [15:0] ir, ir_n;

    logic [2:0] op, rn, rd, rm, cond;
    logic [1:0] sub, sh;
    logic       flag_z, flag_n, flag_v;
    logic       is_mov_imm, is_mov_reg, is_alu, is_mvn, is_cmp;
    logic       is_ldr, is_str, is_br, is_halt, taken;

    assign op   = ir[15:13];
    assign sub  = ir[12:11];
    assign rn   = ir[10:8];
    assign rd   = ir[7:5];
    assign sh   = ir[4:3];
    assign rm   = ir[2:0];
    assign cond = ir[10:8];

    assign flag_z = Z_out[2];
    assign flag_n = Z_out[1];
    assign flag_v = Z_out[0];

    assign is_mov_imm = (op == 3'b110) && (sub == 2'b10);
    assign is_mov_reg = (op == 3'b110) && (sub == 2'b00);
    assign is_alu     = (op == 3'b101);
    assign is_mvn     = is_alu && (sub == 2'b11);
    assign is_cmp     = is_alu && (sub == 2'b01);
    assign is_ldr     = (op == 3'b011) && (sub == 2'b00);
    assign is_str     = (op == 3'b100) && (sub == 2'b00);
    assign is_br      = (op == 3'b001) && (sub == 2'b00);
    assign is_halt    = (op == 3'b111);

    always_comb begin
        case (cond)
            3'b000:  taken = 1'b1;
            3'b001:  taken = flag_z;
            3'b010:  taken = !flag_z;
            3'b011:  taken = flag_n ^ flag_v;
            3'b100:  taken = (flag_n ^ flag_v) | flag_z;
            default: taken = 1'b0;
        endcase
    end

    assign sximm5     = {{11{ir[4]}}, ir[4:0]};
    assign sximm8     = {{8{ir[7]}}, ir[7:0]};
    assign write_data = datapath_out;
    assign PC         = pc;
    assign halted     = (state == S_HALT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IF;
            pc    <= '0;
            ir    <= '0;
            dar   <= '0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            ir    <= ir_n;
            dar   <= dar_n;
        end
    end

    always_comb begin
        state_n  = state;
        pc_n     = pc;
        ir_n     = ir;
        dar_n    = dar;
        mem_cmd  = CMD_NONE;
        mem_addr = pc;
        vsel     = 4'b0000;
        writenum = 3'd0;
        readnum  = 3'd0;
        write    = 1'b0;
        loada    = 1'b0;
        loadb    = 1'b0;
        loadc    = 1'b0;
        loads    = 1'b0;
        asel     = 1'b0;
        bsel     = 1'b0;
        shift    = 2'b00;
        ALUop    = 2'b00;
        // Controls are held inactive while reset is asserted so an
        // in-flight memory command is dropped immediately.
        if (reset_n) begin
            unique case (state)
                S_IF: begin
                    mem_cmd  = CMD_READ;
                    mem_addr = pc;
                    if (mem_ready) begin
                        ir_n    = read_data;
                        pc_n    = pc + 9'd1;
                        state_n = S_DEC;
                    end
                end
                S_DEC: begin
                    unique case (1'b1)
                        is_mov_imm:
                            state_n = S_WRI;
                        is_mov_reg, is_mvn:
                            state_n = S_GETB;
                        (is_alu && !is_mvn), is_ldr, is_str:
                            state_n = S_GETA;
                        is_br: begin
                            if (taken)
                                pc_n = pc + sximm8[8:0];
                            state_n = S_IF;
                        end
                        is_halt:
                            state_n = S_HALT;
                        default:
                            state_n = S_IF;
                    endcase
                end
                S_WRI: begin
                    vsel     = 4'b0010;
                    writenum = rn;
                    write    = 1'b1;
                    state_n  = S_IF;
                end
                S_GETA: begin
                    readnum = rn;
                    loada   = 1'b1;
                    state_n = (is_ldr || is_str) ? S_ADDR : S_GETB;
                end
                S_GETB: begin
                    readnum = rm;
                    loadb   = 1'b1;
                    state_n = S_EXEC;
                end
                S_EXEC: begin
                    shift = sh;
                    bsel  = 1'b0;
                    if (is_mov_reg) begin
                        ALUop = 2'b00;
                        asel  = 1'b1;
                    end else begin
                        ALUop = sub;
                        asel  = 1'b0;
                    end
                    if (is_cmp) begin
                        loads   = 1'b1;
                        state_n = S_IF;
                    end else begin
                        loadc   = 1'b1;
                        state_n = S_WBR;
                    end
                end
                S_WBR: begin
                    vsel     = 4'b1000;
                    writenum = rd;
                    write    = 1'b1;
                    state_n  = S_IF;
                end
                S_ADDR: begin
                    asel    = 1'b0;
                    bsel    = 1'b1;
                    ALUop   = 2'b00;
                    loadc   = 1'b1;
                    state_n = S_LDA;
                end
                S_LDA: begin
                    dar_n   = datapath_out[8:0];
                    state_n = is_ldr ? S_MEMRD : S_GETD;
                end
                S_MEMRD: begin
                    mem_cmd  = CMD_READ;
                    mem_addr = dar;
                    // Register write only in the completing cycle, when
                    // read_data is valid on mdata.
                    if (mem_ready) begin
                        vsel     = 4'b0001;
                        writenum = rd;
                        write    = 1'b1;
                        state_n  = S_IF;
                    end
                end
                S_GETD: begin
                    readnum = rd;
                    loadb   = 1'b1;
                    state_n = S_STOUT;
                end
                S_STOUT: begin
                    asel    = 1'b1;
                    bsel    = 1'b0;
                    ALUop   = 2'b00;
                    loadc   = 1'b1;
                    state_n = S_MEMWR;
                end
                S_MEMWR: begin
                    mem_cmd  = CMD_WRITE;
                    mem_addr = dar;
                    if (mem_ready)
                        state_n = S_IF;
                end
                S_HALT: begin
                    state_n = S_HALT;
                end
                default: begin
                    state_n = S_IF;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_controller.sv
// tb_cpu_controller: table-driven + hand-sequenced checks of cpu_controller.
// The bench models instruction/data memory and scoreboards cycle counts.
module tb_cpu_controller;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] read_data;
    logic        mem_ready;
    logic [15:0] datapath_out;
    logic [2:0]  Z_out;
    logic [1:0]  mem_cmd;
    logic [8:0]  mem_addr;
    logic [15:0] write_data;
    logic [3:0]  vsel;
    logic [2:0]  writenum, readnum;
    logic        write, loada, loadb, loadc, loads, asel, bsel;
    logic [1:0]  shift, ALUop;
    logic [15:0] sximm5, sximm8;
    logic [8:0]  PC;
    logic        halted;

    always #5 clk = ~clk;

    cpu_controller dut (
        .clk(clk), .reset_n(reset_n), .read_data(read_data),
        .mem_ready(mem_ready), .datapath_out(datapath_out), .Z_out(Z_out),
        .mem_cmd(mem_cmd), .mem_addr(mem_addr), .write_data(write_data),
        .vsel(vsel), .writenum(writenum), .readnum(readnum),
        .write(write), .loada(loada), .loadb(loadb), .loadc(loadc),
        .loads(loads), .asel(asel), .bsel(bsel), .shift(shift),
        .ALUop(ALUop), .sximm5(sximm5), .sximm8(sximm8), .PC(PC),
        .halted(halted)
    );

    typedef struct {
        logic [15:0] ir;
        logic [2:0]  z;
        logic [15:0] dp;
        int          cyc;
        logic [8:0]  nxt;
        bit          hlt;
    } vec_t;

    typedef struct {
        int         cyc;
        logic [8:0] nxt;
        bit         hlt;
    } exp_t;

    vec_t        vecs[16];
    exp_t        sb[$];
    logic [15:0] mem [0:511];
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic rdy);
        mem_ready = rdy;
        #1;
        read_data = mem[mem_addr];
        #1;
    endtask

    task automatic adv();
        if (mem_cmd == 2'b10 && mem_ready)
            mem[mem_addr] = write_data;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n      = 1'b0;
        mem_ready    = 1'b0;
        read_data    = '0;
        datapath_out = '0;
        Z_out        = '0;
        for (int i = 0; i < 512; i++)
            mem[i] = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic steps(input int k);
        for (int i = 0; i < k; i++) begin
            drive(1'b1);
            adv();
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        exp_t e;
        int   n;
        bit   done;

        vecs[0]  = '{16'hD0FD, 3'b000, 16'h0000, 3, 9'd1,   1'b0};
        vecs[1]  = '{16'hC040, 3'b000, 16'h0000, 5, 9'd1,   1'b0};
        vecs[2]  = '{16'hB841, 3'b000, 16'h0000, 5, 9'd1,   1'b0};
        vecs[3]  = '{16'hA148, 3'b000, 16'h0000, 6, 9'd1,   1'b0};
        vecs[4]  = '{16'hB148, 3'b000, 16'h0000, 6, 9'd1,   1'b0};
        vecs[5]  = '{16'hA948, 3'b000, 16'h0000, 5, 9'd1,   1'b0};
        vecs[6]  = '{16'h6162, 3'b000, 16'h0030, 6, 9'd1,   1'b0};
        vecs[7]  = '{16'h8162, 3'b000, 16'h0040, 8, 9'd1,   1'b0};
        vecs[8]  = '{16'h2003, 3'b000, 16'h0000, 2, 9'd4,   1'b0};
        vecs[9]  = '{16'h21FF, 3'b100, 16'h0000, 2, 9'd0,   1'b0};
        vecs[10] = '{16'h21FF, 3'b000, 16'h0000, 2, 9'd1,   1'b0};
        vecs[11] = '{16'h22FE, 3'b000, 16'h0000, 2, 9'd511, 1'b0};
        vecs[12] = '{16'h2305, 3'b010, 16'h0000, 2, 9'd6,   1'b0};
        vecs[13] = '{16'h2405, 3'b011, 16'h0000, 2, 9'd1,   1'b0};
        vecs[14] = '{16'h4000, 3'b000, 16'h0000, 2, 9'd1,   1'b0};
        vecs[15] = '{16'hE000, 3'b000, 16'h0000, 2, 9'd0,   1'b1};

        // Reset state and first fetch
        reset_n = 1'b0;
        mem_ready = 1'b1;
        read_data = '0;
        datapath_out = '0;
        Z_out = '0;
        for (int i = 0; i < 512; i++)
            mem[i] = 16'h0000;
        repeat (2) @(posedge clk);
        #2;
        chk("reset_cmd", 32'(mem_cmd), 32'h0);
        chk("reset_pc", 32'(PC), 32'h0);
        chk("reset_halted", 32'(halted), 32'h0);
        reset_n = 1'b1;
        drive(1'b1);
        chk("if_cmd", 32'(mem_cmd), 32'h1);
        chk("if_addr", 32'(mem_addr), 32'h0);
        adv();
        drive(1'b1);
        chk("dec_pc", 32'(PC), 32'h1);

        // MOV R0,#-3
        do_reset();
        mem[0] = 16'hD0FD;
        steps(2);
        drive(1'b1);
        chk("wri_write", 32'(write), 32'h1);
        chk("wri_writenum", 32'(writenum), 32'h0);
        chk("wri_vsel", 32'(vsel), 32'h2);
        chk("wri_sximm8", 32'(sximm8), 32'hFFFD);
        adv();
        drive(1'b1);
        chk("wri_next_cmd", 32'(mem_cmd), 32'h1);
        chk("wri_next_addr", 32'(mem_addr), 32'h1);

        // ADD R2,R1,R0,LSL#1
        do_reset();
        mem[0] = 16'hA148;
        steps(2);
        drive(1'b1);
        chk("geta_readnum", 32'(readnum), 32'h1);
        chk("geta_loada", 32'(loada), 32'h1);
        adv();
        drive(1'b1);
        chk("getb_readnum", 32'(readnum), 32'h0);
        chk("getb_loadb", 32'(loadb), 32'h1);
        adv();
        drive(1'b1);
        chk("exec_shift", 32'(shift), 32'h1);
        chk("exec_aluop", 32'(ALUop), 32'h0);
        chk("exec_loadc", 32'(loadc), 32'h1);
        chk("exec_asel", 32'(asel), 32'h0);
        adv();
        drive(1'b1);
        chk("wbr_writenum", 32'(writenum), 32'h2);
        chk("wbr_write", 32'(write), 32'h1);
        chk("wbr_vsel", 32'(vsel), 32'h8);

        // LDR R3,[R1,#2] with three memory wait cycles
        do_reset();
        mem[0] = 16'h6162;
        datapath_out = 16'h0012;
        steps(3);
        drive(1'b1);
        chk("addr_bsel", 32'(bsel), 32'h1);
        chk("addr_loadc", 32'(loadc), 32'h1);
        adv();
        steps(1);
        for (int k = 0; k < 3; k++) begin
            drive(1'b0);
            chk("memrd_wait_cmd", 32'(mem_cmd), 32'h1);
            chk("memrd_wait_addr", 32'(mem_addr), 32'h12);
            chk("memrd_wait_write", 32'(write), 32'h0);
            adv();
        end
        drive(1'b1);
        chk("memrd_cmd", 32'(mem_cmd), 32'h1);
        chk("memrd_addr", 32'(mem_addr), 32'h12);
        chk("memrd_write", 32'(write), 32'h1);
        chk("memrd_writenum", 32'(writenum), 32'h3);
        chk("memrd_vsel", 32'(vsel), 32'h1);
        adv();
        drive(1'b1);
        chk("memrd_next_addr", 32'(mem_addr), 32'h1);
        chk("memrd_next_write", 32'(write), 32'h0);

        // BEQ #-2 fetched at address 5, both flag outcomes
        for (int zz = 0; zz < 2; zz++) begin
            do_reset();
            mem[5] = 16'h21FE;
            Z_out = (zz == 1) ? 3'b100 : 3'b000;
            steps(10);
            drive(1'b1);
            chk("beq_fetch_addr", 32'(mem_addr), 32'h5);
            adv();
            steps(1);
            drive(1'b1);
            chk("beq_next_addr", 32'(mem_addr), (zz == 1) ? 32'h4 : 32'h6);
        end

        // HALT is absorbing
        do_reset();
        mem[0] = 16'hE000;
        steps(2);
        for (int k = 0; k < 6; k++) begin
            drive(1'b1);
            chk("halt_state", 32'({halted, mem_cmd}), 32'h4);
            adv();
        end

        // Reset asserted in the middle of MEMWR
        do_reset();
        mem[0] = 16'h8162;
        datapath_out = 16'h0020;
        steps(7);
        drive(1'b0);
        chk("memwr_cmd", 32'(mem_cmd), 32'h2);
        chk("memwr_addr", 32'(mem_addr), 32'h20);
        reset_n = 1'b0;
        #1;
        chk("memwr_reset_cmd", 32'(mem_cmd), 32'h0);
        chk("memwr_reset_pc", 32'(PC), 32'h0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Table-driven instruction timing with a scoreboard
        for (int v = 0; v < 16; v++) begin
            do_reset();
            mem[0] = vecs[v].ir;
            datapath_out = vecs[v].dp;
            Z_out = vecs[v].z;
            sb.push_back('{vecs[v].cyc, vecs[v].nxt, vecs[v].hlt});
            n = 0;
            done = 1'b0;
            for (int c = 0; c < 30 && !done; c++) begin
                drive(1'b1);
                if (halted || (n > 0 && mem_cmd == 2'b01 && !write))
                    done = 1'b1;
                else begin
                    n++;
                    adv();
                end
            end
            e = sb.pop_front();
            chk($sformatf("vec%0d_done", v), 32'(done), 32'h1);
            chk($sformatf("vec%0d_cycles", v), 32'(n), 32'(e.cyc));
            if (e.hlt)
                chk($sformatf("vec%0d_halted", v), 32'(halted), 32'h1);
            else
                chk($sformatf("vec%0d_next", v), 32'(mem_addr), 32'(e.nxt));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
